// File: rtl/counter_sweep_pkg.sv
// counter_sweep_pkg
// Shared types for the counter sweep controller:
//   mode_t  - sweep pattern selected by the configuration (UP, DOWN, PINGPONG, RSVD)
//   state_t - controller states (IDLE, ARMED, RUN)
//   start_at_hi() - tells which bound a run starts from for a given mode
package counter_sweep_pkg;

   typedef enum logic [1:0] {
      MODE_UP       = 2'd0,
      MODE_DOWN     = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // DOWN sweeps start at the upper bound counting down; every other mode
   // starts at the lower bound counting up.
   function automatic logic start_at_hi(input mode_t mode);
      return (mode == MODE_DOWN);
   endfunction

endpackage

// File: rtl/counter_sweep_ctrl_sweep_step.sv
// sweep_step
// Combinational next-position logic for one step of the sweep counter.
// Ports:
//   count, dir      - current position and direction (1 = up)
//   lo, hi          - inclusive bounds, lo <= hi is guaranteed by the caller
//   mode            - sweep pattern
//   next_count      - position after one step
//   next_dir        - direction after one step
//   sweep_done      - this step completes one sweep
module sweep_step
   import counter_sweep_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  mode_t            mode,
   output logic [WIDTH-1:0] next_count,
   output logic             next_dir,
   output logic             sweep_done
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      next_count = count;
      next_dir   = dir;
      sweep_done = 1'b0;
      if (lo == hi) begin
         // Degenerate range: position never moves, every step is a sweep.
         sweep_done = 1'b1;
      end else begin
         case (mode)
            MODE_UP: begin
               next_dir = 1'b1;
               if (count == hi) begin
                  next_count = lo;
                  sweep_done = 1'b1;
               end else begin
                  next_count = count + ONE;
               end
            end
            MODE_DOWN: begin
               next_dir = 1'b0;
               if (count == lo) begin
                  next_count = hi;
                  sweep_done = 1'b1;
               end else begin
                  next_count = count - ONE;
               end
            end
            MODE_PINGPONG: begin
               if (dir) begin
                  if (count == hi) begin
                     next_dir   = 1'b0;
                     next_count = hi - ONE;
                  end else begin
                     next_count = count + ONE;
                  end
               end else begin
                  if (count == lo) begin
                     next_dir   = 1'b1;
                     next_count = lo + ONE;
                  end else begin
                     next_count = count - ONE;
                  end
               end
               // A ping-pong sweep ends when the down leg arrives at lo.
               // This also covers hi = lo+1, where the turn at hi lands on lo.
               sweep_done = !next_dir && (next_count == lo);
            end
            default: begin
               next_count = count;
            end
         endcase
      end
   end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sequencing controller for a bounded up/down counter. A sweep configuration
// is loaded over a valid/ready handshake, the run is armed, started with
// `start`, stepped once per `step`, and ends with a `done` pulse after the
// programmed number of sweeps (or never, when the sweep count is 0).
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   cfg_valid, cfg_ready  - configuration handshake
//   cfg_lo, cfg_hi        - inclusive bounds
//   cfg_mode              - 0 UP wrap, 1 DOWN wrap, 2 PINGPONG, 3 reserved
//   cfg_sweeps            - sweeps per run, 0 = run forever
//   start, stop, step     - run control strobes
//   count, dir            - current position and direction (1 = up)
//   busy                  - high while running
//   done, err             - one-cycle completion / rejection pulses
//
// Handshake: a configuration transfers on any rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high outside RUN and does not depend
// on cfg_valid. A transferred configuration is either accepted or rejected
// (err) in that same edge; there is no back-pressure beyond cfg_ready.
module counter_sweep_ctrl
   import counter_sweep_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int SWEEPS_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [WIDTH-1:0]    cfg_lo,
   input  logic [WIDTH-1:0]    cfg_hi,
   input  logic [1:0]          cfg_mode,
   input  logic [SWEEPS_W-1:0] cfg_sweeps,
   input  logic                start,
   input  logic                stop,
   input  logic                step,
   output logic [WIDTH-1:0]    count,
   output logic                dir,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [SWEEPS_W-1:0] SW_ONE = {{(SWEEPS_W-1){1'b0}}, 1'b1};

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    lo_q, lo_nxt;
   logic [WIDTH-1:0]    hi_q, hi_nxt;
   mode_t               mode_q, mode_nxt;
   logic [SWEEPS_W-1:0] sweeps_q, sweeps_nxt;
   logic [SWEEPS_W-1:0] sweep_cnt, sweep_cnt_nxt;
   logic [WIDTH-1:0]    count_nxt;
   logic                dir_nxt;
   logic                done_nxt;
   logic                err_nxt;

   logic [WIDTH-1:0]    step_count;
   logic                step_dir;
   logic                step_sweep_done;

   logic                cfg_fire;
   logic                cfg_ok;
   mode_t               cfg_mode_e;
   logic [SWEEPS_W-1:0] sweep_inc;
   logic                final_sweep;

   sweep_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .count      (count),
      .dir        (dir),
      .lo         (lo_q),
      .hi         (hi_q),
      .mode       (mode_q),
      .next_count (step_count),
      .next_dir   (step_dir),
      .sweep_done (step_sweep_done)
   );

   assign cfg_mode_e = mode_t'(cfg_mode);
   assign cfg_fire   = cfg_valid && cfg_ready;
   assign cfg_ok     = (cfg_lo <= cfg_hi) && (cfg_mode_e != MODE_RSVD);

   // Sweep counter saturates so a forever run cannot wrap it.
   assign sweep_inc   = (sweep_cnt == {SWEEPS_W{1'b1}}) ? sweep_cnt : sweep_cnt + SW_ONE;
   assign final_sweep = step_sweep_done && (sweeps_q != '0) && (sweep_inc == sweeps_q);

   always_comb begin
      state_nxt     = state;
      lo_nxt        = lo_q;
      hi_nxt        = hi_q;
      mode_nxt      = mode_q;
      sweeps_nxt    = sweeps_q;
      sweep_cnt_nxt = sweep_cnt;
      count_nxt     = count;
      dir_nxt       = dir;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;
      case (state)
         ST_IDLE, ST_ARMED: begin
            // A configuration transfer takes precedence over start.
            if (cfg_fire) begin
               if (cfg_ok) begin
                  lo_nxt     = cfg_lo;
                  hi_nxt     = cfg_hi;
                  mode_nxt   = cfg_mode_e;
                  sweeps_nxt = cfg_sweeps;
                  state_nxt  = ST_ARMED;
                  if (start_at_hi(cfg_mode_e)) begin
                     count_nxt = cfg_hi;
                     dir_nxt   = 1'b0;
                  end else begin
                     count_nxt = cfg_lo;
                     dir_nxt   = 1'b1;
                  end
               end else begin
                  err_nxt = 1'b1;
               end
            end else if ((state == ST_ARMED) && start) begin
               state_nxt     = ST_RUN;
               sweep_cnt_nxt = '0;
            end
         end
         ST_RUN: begin
            if (stop || (step && final_sweep)) begin
               state_nxt = ST_ARMED;
               done_nxt  = !stop;
               if (start_at_hi(mode_q)) begin
                  count_nxt = hi_q;
                  dir_nxt   = 1'b0;
               end else begin
                  count_nxt = lo_q;
                  dir_nxt   = 1'b1;
               end
            end else if (step) begin
               count_nxt = step_count;
               dir_nxt   = step_dir;
               if (step_sweep_done) begin
                  sweep_cnt_nxt = sweep_inc;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         lo_q      <= '0;
         hi_q      <= '1;
         mode_q    <= MODE_PINGPONG;
         sweeps_q  <= '0;
         sweep_cnt <= '0;
         count     <= '0;
         dir       <= 1'b1;
         busy      <= 1'b0;
         cfg_ready <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         lo_q      <= lo_nxt;
         hi_q      <= hi_nxt;
         mode_q    <= mode_nxt;
         sweeps_q  <= sweeps_nxt;
         sweep_cnt <= sweep_cnt_nxt;
         count     <= count_nxt;
         dir       <= dir_nxt;
         // Status flags are registered from the next state so they line up
         // with the state register itself.
         busy      <= (state_nxt == ST_RUN);
         cfg_ready <= (state_nxt != ST_RUN);
         done      <= done_nxt;
         err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;

   logic       clk;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_lo;
   logic [2:0] cfg_hi;
   logic [1:0] cfg_mode;
   logic [3:0] cfg_sweeps;
   logic       start;
   logic       stop;
   logic       step;
   logic [2:0] count;
   logic       dir;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: run state plus number of steps taken since the run
   // position was last reset to its start value.
   int m_state;  // 0 idle, 1 armed, 2 run
   int m_lo, m_hi, m_mode, m_sweeps, m_n;

   counter_sweep_ctrl #(.WIDTH(3), .SWEEPS_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_lo     (cfg_lo),
      .cfg_hi     (cfg_hi),
      .cfg_mode   (cfg_mode),
      .cfg_sweeps (cfg_sweeps),
      .start      (start),
      .stop       (stop),
      .step       (step),
      .count      (count),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int span();
      return m_hi - m_lo + 1;
   endfunction

   function automatic int period();
      if (span() == 1) return 1;
      if (m_mode == 2) return 2 * (span() - 1);
      return span();
   endfunction

   function automatic int sweeps_of(input int n);
      return n / period();
   endfunction

   function automatic int exp_count();
      int p;
      p = m_n % period();
      if (span() == 1) return m_lo;
      if (m_mode == 0) return m_lo + p;
      if (m_mode == 1) return m_hi - p;
      return (p <= span() - 1) ? m_lo + p : m_lo + period() - p;
   endfunction

   function automatic int exp_dir();
      int p;
      p = m_n % period();
      if (m_mode == 0) return 1;
      if (m_mode == 1) return 0;
      if (span() == 1 || m_n == 0) return 1;
      if (p == 0) return 0;
      return (p <= span() - 1) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then
   // compare every output 1 time unit after the edge.
   task automatic tick(input logic v, input int lo, input int hi, input int md, input int sw,
                       input logic st, input logic sp, input logic stp);
      int e_done, e_err;
      cfg_valid  = v;
      cfg_lo     = 3'(lo);
      cfg_hi     = 3'(hi);
      cfg_mode   = 2'(md);
      cfg_sweeps = 4'(sw);
      start      = st;
      stop       = sp;
      step       = stp;
      @(posedge clk);
      e_done = 0;
      e_err  = 0;
      if (!rst) begin
         m_state = 0; m_lo = 0; m_hi = 7; m_mode = 2; m_sweeps = 0; m_n = 0;
      end else if (m_state != 2) begin
         if (v) begin
            if (lo > hi || md == 3) begin
               e_err = 1;
            end else begin
               m_lo = lo; m_hi = hi; m_mode = md; m_sweeps = sw; m_n = 0; m_state = 1;
            end
         end else if (m_state == 1 && st) begin
            m_state = 2;
            m_n = 0;
         end
      end else if (sp) begin
         m_state = 1;
         m_n = 0;
      end else if (stp) begin
         m_n++;
         if (m_sweeps != 0 && sweeps_of(m_n) == m_sweeps) begin
            e_done = 1;
            m_state = 1;
            m_n = 0;
         end
      end
      #1;
      chk("count", 32'(count), 32'(exp_count()));
      chk("dir", 32'(dir), 32'(exp_dir()));
      chk("busy", 32'(busy), 32'(m_state == 2));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_state != 2));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
   endtask

   initial begin
      int steps, r, lo, hi;

      // Reset held 2 cycles, start asserted has no effect.
      rst = 1'b0;
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      rst = 1'b1;
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 1);

      // PINGPONG 2..5, one sweep.
      tick(1, 2, 5, 2, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 0, 0, 1);   // armed: step ignored

      // UP 0..7, two sweeps, 16 steps.
      tick(1, 0, 7, 0, 2, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 16; i++) tick(0, 0, 0, 0, 0, 0, 0, 1);

      // Rejected configurations leave everything unchanged.
      tick(1, 6, 1, 0, 1, 0, 0, 0);
      tick(1, 1, 4, 3, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 1);
      tick(1, 6, 1, 0, 1, 0, 0, 1);   // cfg ignored in RUN, no err

      // stop together with step: no advance, reload, no done.
      tick(0, 0, 0, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 0, 1, 1);
      tick(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset mid-run.
      tick(1, 3, 6, 1, 3, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      tick(0, 0, 0, 0, 0, 0, 0, 1);
      rst = 1'b1;
      tick(0, 0, 0, 0, 0, 1, 0, 1);

      // Forever DOWN 1..6 with random gaps.
      tick(1, 1, 6, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      steps = 0;
      while (steps < 100) begin
         r = int'($urandom_range(0, 2));
         tick(0, 0, 0, 0, 0, 0, 0, r != 0);
         if (r != 0) steps++;
      end
      tick(0, 0, 0, 0, 0, 0, 1, 0);

      // Random configurations and control strobes.
      for (int it = 0; it < 16; it++) begin
         lo = int'($urandom_range(0, 7));
         hi = (it % 4 == 3) ? lo : int'($urandom_range(0, 7));
         tick(0, 0, 0, 0, 0, 0, 1, 0);
         tick(1, lo, hi, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0, 0);
         tick(0, 0, 0, 0, 0, 1, 0, 0);
         for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 15));
            tick(0, 0, 0, 0, 0, r == 0, r == 1, r > 3);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencing controller for a bounded up/down counter. It accepts a sweep configuration (lower/upper bound, mode, sweep count) over a valid/ready handshake and arms on `start`. It then steps the counter once per `step` strobe, in up-wrap, down-wrap or ping-pong mode. After the programmed number of sweeps it pulses `done` and re-arms. It sits between a host/sequencer and any logic consuming a gradual count pattern.

## Interface
- `WIDTH`, 3, counter width.
- `SWEEPS_W`, 4, width of the sweep-count field.

- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset (0 = reset).
- `cfg_valid`  input  1  configuration offered.
- `cfg_ready`  output  1  configuration can be accepted.
- `cfg_lo`  input  WIDTH  lower bound.
- `cfg_hi`  input  WIDTH  upper bound.
- `cfg_mode`  input  2  0 = UP wrap, 1 = DOWN wrap, 2 = PINGPONG, 3 = reserved.
- `cfg_sweeps`  input  SWEEPS_W  sweeps to run; 0 = run forever.
- `start`  input  1  begin the run (honoured in ARMED only).
- `stop`  input  1  abort the run (honoured in RUN only).
- `step`  input  1  advance the count by one position.
- `count`  output  WIDTH  current count.
- `dir`  output  1  1 = counting up, 0 = counting down.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse when the programmed sweeps complete.
- `err`  output  1  one-cycle pulse when a configuration is rejected.

## Operation
- States are IDLE, ARMED and RUN. Reset enters IDLE.
- Reset values:
  - `count` = 0, `dir` = 1.
  - `busy`, `done`, `err` = 0.
  - Stored config: lo = 0, hi = 2^WIDTH−1, mode = PINGPONG, sweeps = 0.
- `cfg_ready` = 1 in IDLE and ARMED, 0 in RUN.
- A handshake occurs when `cfg_valid` and `cfg_ready` are both high.
- A configuration is rejected if `cfg_lo` > `cfg_hi` or `cfg_mode` = 3. On rejection:
  - `err` pulses.
  - Stored config, `count`, `dir` and state are unchanged.
- On acceptance:
  - The configuration is stored and the state moves to ARMED.
  - The start value is loaded: UP and PINGPONG load `count` = lo, `dir` = 1; DOWN loads `count` = hi, `dir` = 0.
- In ARMED, `start` moves to RUN and clears the sweep counter. `start` is ignored in IDLE and RUN.
- In RUN, `step` advances the count according to the mode:
  - UP: `count`+1. At hi, wrap to lo; the wrap completes one sweep.
  - DOWN: `count`−1. At lo, wrap to hi; the wrap completes one sweep.
  - PINGPONG, moving up: at hi, set `dir` = 0 and count hi−1.
  - PINGPONG, moving down: at lo, set `dir` = 1 and count lo+1.
  - PINGPONG sweep completion: a sweep completes on the step that lands `count` on lo while moving down.
  - lo = hi, any mode: `count` stays constant and every step completes one sweep.
- When completed sweeps equal a nonzero `cfg_sweeps`:
  - `done` pulses.
  - `count` and `dir` reload the start value.
  - The state returns to ARMED.
- `stop` in RUN returns to ARMED and reloads the start value. `done` does not pulse.
- `stop` has priority over `step` in the same cycle.
- `busy` = 1 exactly while in RUN.
- All arithmetic is modulo 2^WIDTH, but bounds keep it in range. The sweep counter is SWEEPS_W bits and saturates when `cfg_sweeps` = 0.

## Timing
- All outputs are registered.
- `count`/`dir` update on the edge that samples `step`. A change is visible 1 cycle after the strobe.
- `done` is high for the one cycle after the edge that samples the final step. The reloaded start value is visible in that same cycle.
- `err` is high for the one cycle after the rejected handshake.
- `busy` rises 1 cycle after `start` and falls 1 cycle after the final step or `stop`.
- `rst` = 0 overrides everything, including mid-run. Reset values hold from the following cycle.

## Structure
- Package `counter_sweep_pkg` holds:
  - the mode enum (UP, DOWN, PINGPONG, RSVD);
  - the state enum (IDLE, ARMED, RUN).
- Sub-module `sweep_step` is combinational. It takes count, dir, lo, hi and mode, and returns next count, next dir and `sweep_done`.
- The top level holds the FSM, the config registers and the sweep counter.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles → `count` = 0, `dir` = 1, `cfg_ready` = 1, `busy` = 0; `start` has no effect.
- PINGPONG, lo = 2, hi = 5, sweeps = 1, `start`, then `step` every cycle → `count` 3,4,5,4,3,2. `done` pulses with 2 visible; the state is ARMED and `busy` = 0.
- UP, lo = 0, hi = 7, sweeps = 2, 16 steps → `count` wraps 7→0 twice; `done` pulses after the 16th step only.
- Config lo = 6, hi = 1, then mode = 3 → `err` pulses each time; stored config, `count` and state are unchanged.
- RUN with `stop` and `step` in the same cycle → no advance, ARMED, start value reloaded, no `done`. Separately, `rst` = 0 mid-run → reset values next cycle.
- sweeps = 0, DOWN, lo = 1, hi = 6, 100 steps with random gaps → `count` holds during gaps, wraps 1→6, `done` never asserts.
